// File: rtl/kb_ram_write_arbiter_pkg.sv
// Shared constants and types for the keyboard / CPU RAM write arbiter.
//   DEF_*           default values for the top-level parameters
//   KEY_CODE_WIDTH  width of a PS/2 scan code
//   KEY_DATA_PAD    zero bits prepended to a scan code to fill a RAM word
//   wr_src_e        which source owns the RAM write port this cycle
package kb_ram_write_arbiter_pkg;

    localparam int         DEF_DATA_WIDTH = 16;
    localparam int         DEF_ADDR_WIDTH = 8;
    localparam int         DEF_FIFO_DEPTH = 4;
    localparam int         DEF_RING_SIZE  = 16;
    localparam logic [7:0] DEF_RING_BASE  = 8'hE0;

    localparam int KEY_CODE_WIDTH = 8;
    localparam int KEY_DATA_PAD   = DEF_DATA_WIDTH - KEY_CODE_WIDTH;

    typedef enum logic [1:0] {
        WR_SRC_IDLE = 2'd0,
        WR_SRC_CPU  = 2'd1,
        WR_SRC_KEY  = 2'd2
    } wr_src_e;

endpackage

// File: rtl/kb_code_fifo.sv
// Small synchronous FIFO holding captured scan codes until the RAM port is free.
//   Clock, Reset   system clock, asynchronous active-high reset
//   push_i/wdata_i write one entry; accepted when not full, or when full and
//                  popping in the same cycle
//   pop_i          consume the head entry (ignored when empty)
//   rdata_o        head entry, valid while empty_o is low
//   full_o/empty_o occupancy flags
module kb_code_fifo
    import kb_ram_write_arbiter_pkg::*;
#(
    parameter int DEPTH = DEF_FIFO_DEPTH,
    parameter int WIDTH = KEY_CODE_WIDTH
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int               PTR_W    = $clog2(DEPTH);
    localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == '0);
    assign rdata_o = mem_q[rd_ptr_q];

    // Space is judged after a same-cycle pop, so a full FIFO that pops still accepts.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only visible through count_q.
    always_ff @(posedge Clock) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/kb_ram_write_arbiter.sv
// Shares the data RAM write port between the CPU and the PS/2 keyboard path.
// CPU writes pass straight through with zero latency; scan codes are
// synchronised, queued in kb_code_fifo and written into a circular ring of RAM
// on cycles the CPU leaves the port idle.
//   Clock, Reset                       system clock, async active-high reset
//   iCpuWriteEnable/Address/DataIn     CPU write request
//   iKeyCode, iKeyCodeReady            scan code and its asynchronous ready flag
//   iConsume                           software read one ring entry
//   iClearOverflow                     clears oOverflow
//   oWriteEnable/Address/oDataIn       RAM write port
//   oRingHead                          next ring slot to be written
//   oPending                           unread ring entries (0..RING_SIZE)
//   oOverflow                          sticky: a scan code was dropped
//   oKeyWritten                        pulse on each keyboard RAM write
module kb_ram_write_arbiter
    import kb_ram_write_arbiter_pkg::*;
#(
    parameter int                    DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int                    ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int                    FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter logic [ADDR_WIDTH-1:0] RING_BASE  = DEF_RING_BASE,
    parameter int                    RING_SIZE  = DEF_RING_SIZE
) (
    input  logic                         Clock,
    input  logic                         Reset,
    input  logic                         iCpuWriteEnable,
    input  logic [ADDR_WIDTH-1:0]        iCpuWriteAddress,
    input  logic [DATA_WIDTH-1:0]        iCpuDataIn,
    input  logic [7:0]                   iKeyCode,
    input  logic                         iKeyCodeReady,
    input  logic                         iConsume,
    input  logic                         iClearOverflow,
    output logic                         oWriteEnable,
    output logic [ADDR_WIDTH-1:0]        oWriteAddress,
    output logic [DATA_WIDTH-1:0]        oDataIn,
    output logic [$clog2(RING_SIZE)-1:0] oRingHead,
    output logic [$clog2(RING_SIZE):0]   oPending,
    output logic                         oOverflow,
    output logic                         oKeyWritten
);

    localparam int                HEAD_W    = $clog2(RING_SIZE);
    localparam int                KEY_PAD   = DATA_WIDTH - KEY_CODE_WIDTH;
    localparam logic [HEAD_W:0]   RING_FULL = (HEAD_W + 1)'(RING_SIZE);

    logic              sync1_q, sync2_q, prev_q;
    logic              key_push;
    logic              fifo_full, fifo_empty;
    logic [7:0]        fifo_rdata;
    logic              key_drop;
    logic              kb_write;
    logic              pend_dec;
    wr_src_e           wr_src;

    logic [HEAD_W-1:0] head_q, head_d;
    logic [HEAD_W:0]   pending_q, pending_d;
    logic              overflow_q, overflow_d;

    // Two flops for metastability, a third to find the rising edge.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= iKeyCodeReady;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign key_push = sync2_q && !prev_q;

    kb_code_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (KEY_CODE_WIDTH)
    ) u_fifo (
        .Clock   (Clock),
        .Reset   (Reset),
        .push_i  (key_push),
        .wdata_i (iKeyCode),
        .pop_i   (kb_write),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // A push into a full FIFO survives only if this cycle also drains an entry.
    assign key_drop = key_push && fifo_full && !kb_write;

    always_comb begin
        wr_src = WR_SRC_IDLE;
        if (iCpuWriteEnable) begin
            wr_src = WR_SRC_CPU;
        end else if (!fifo_empty && (pending_q != RING_FULL)) begin
            wr_src = WR_SRC_KEY;
        end
    end

    assign kb_write = (wr_src == WR_SRC_KEY);

    always_comb begin
        oWriteEnable  = 1'b0;
        oWriteAddress = '0;
        oDataIn       = '0;
        oKeyWritten   = 1'b0;
        case (wr_src)
            WR_SRC_CPU: begin
                oWriteEnable  = 1'b1;
                oWriteAddress = iCpuWriteAddress;
                oDataIn       = iCpuDataIn;
            end
            WR_SRC_KEY: begin
                oWriteEnable  = 1'b1;
                oWriteAddress = RING_BASE + ADDR_WIDTH'(head_q);
                oDataIn       = {{KEY_PAD{1'b0}}, fifo_rdata};
                oKeyWritten   = 1'b1;
            end
            default: ;
        endcase
    end

    assign pend_dec = iConsume && (pending_q != '0);

    always_comb begin
        head_d     = head_q;
        pending_d  = pending_q;
        overflow_d = overflow_q;
        if (kb_write) head_d = head_q + 1'b1;
        case ({kb_write, pend_dec})
            2'b10:   pending_d = pending_q + 1'b1;
            2'b01:   pending_d = pending_q - 1'b1;
            default: pending_d = pending_q;
        endcase
        // A drop wins over a same-cycle clear so the loss is never hidden.
        if (key_drop) begin
            overflow_d = 1'b1;
        end else if (iClearOverflow) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            head_q     <= '0;
            pending_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            head_q     <= head_d;
            pending_q  <= pending_d;
            overflow_q <= overflow_d;
        end
    end

    assign oRingHead = head_q;
    assign oPending  = pending_q;
    assign oOverflow = overflow_q;

endmodule

// File: tb/tb_kb_ram_write_arbiter.sv
// Self-checking bench for kb_ram_write_arbiter: a vector table for the
// CPU/keyboard arbitration window plus directed multi-cycle sequences.
module tb_kb_ram_write_arbiter;

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic        iCpuWriteEnable = 1'b0;
    logic [7:0]  iCpuWriteAddress = '0;
    logic [15:0] iCpuDataIn = '0;
    logic [7:0]  iKeyCode = '0;
    logic        iKeyCodeReady = 1'b0;
    logic        iConsume = 1'b0;
    logic        iClearOverflow = 1'b0;
    logic        oWriteEnable;
    logic [7:0]  oWriteAddress;
    logic [15:0] oDataIn;
    logic [3:0]  oRingHead;
    logic [4:0]  oPending;
    logic        oOverflow;
    logic        oKeyWritten;

    int n_vec = 0;
    int n_err = 0;

    logic [23:0] kw_log [$];

    typedef struct {
        logic        we;
        logic [7:0]  addr;
        logic [15:0] data;
        logic        kr;
        logic [7:0]  kc;
        logic        exp_we;
        logic [7:0]  exp_addr;
        logic [15:0] exp_data;
        logic        exp_kw;
    } vec_t;

    vec_t       tbl [16];
    logic [7:0] t2_codes [3];

    kb_ram_write_arbiter dut (
        .Clock            (Clock),
        .Reset            (Reset),
        .iCpuWriteEnable  (iCpuWriteEnable),
        .iCpuWriteAddress (iCpuWriteAddress),
        .iCpuDataIn       (iCpuDataIn),
        .iKeyCode         (iKeyCode),
        .iKeyCodeReady    (iKeyCodeReady),
        .iConsume         (iConsume),
        .iClearOverflow   (iClearOverflow),
        .oWriteEnable     (oWriteEnable),
        .oWriteAddress    (oWriteAddress),
        .oDataIn          (oDataIn),
        .oRingHead        (oRingHead),
        .oPending         (oPending),
        .oOverflow        (oOverflow),
        .oKeyWritten      (oKeyWritten)
    );

    always #5 Clock = ~Clock;

    // Record every keyboard write mid-cycle, away from the active edge.
    always @(negedge Clock) begin
        if (!Reset && oKeyWritten) kw_log.push_back({oWriteAddress, oDataIn});
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_log(input string name, input int idx, input logic [23:0] exp);
        if (kw_log.size() > idx) begin
            check(name, 32'(kw_log[idx]), 32'(exp));
        end else begin
            n_vec++;
            n_err++;
            $display("FAIL %s: log has %0d entries, entry %0d expected %0h", name, kw_log.size(), idx, exp);
        end
    endtask

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        step();
        step();
        Reset = 1'b0;
        step();
        kw_log.delete();
    endtask

    task automatic send_key(input logic [7:0] code);
        iKeyCode = code;
        iKeyCodeReady = 1'b1;
        step();
        step();
        step();
        iKeyCodeReady = 1'b0;
        step();
        step();
    endtask

    initial begin
        // ---- reset state ----
        #2;
        check("rst_active_outputs",
              {oWriteEnable, oWriteAddress, oDataIn, oRingHead, oPending, oOverflow, oKeyWritten},
              32'h0);
        step();
        Reset = 1'b0;
        step();
        check("rst_released_outputs",
              {oWriteEnable, oWriteAddress, oDataIn, oRingHead, oPending, oOverflow, oKeyWritten},
              32'h0);

        // ---- single key latency ----
        iKeyCode = 8'h1C;
        iKeyCodeReady = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            check("t1_no_early_write", {oWriteEnable, oKeyWritten}, 32'h0);
            step();
        end
        #1;
        check("t1_write", {oWriteEnable, oWriteAddress, oDataIn, oKeyWritten},
              {6'd0, 1'b1, 8'hE0, 16'h001C, 1'b1});
        step();
        iKeyCodeReady = 1'b0;
        #1;
        check("t1_after_write", {oWriteEnable, oKeyWritten, oRingHead, oPending},
              {2'b00, 4'd1, 5'd1});
        step();
        step();
        check("t1_single_pulse", kw_log.size(), 1);

        // ---- CPU busy window with three keys arriving ----
        do_reset();
        t2_codes[0] = 8'h1C;
        t2_codes[1] = 8'h32;
        t2_codes[2] = 8'h21;
        for (int i = 0; i < 12; i++) begin
            tbl[i] = '{we: 1'b1, addr: 8'h10 + 8'(i), data: 16'hA000 + 16'(i),
                       kr: ((i % 4) < 2), kc: t2_codes[i / 4],
                       exp_we: 1'b1, exp_addr: 8'h10 + 8'(i), exp_data: 16'hA000 + 16'(i),
                       exp_kw: 1'b0};
        end
        for (int i = 12; i < 15; i++) begin
            tbl[i] = '{we: 1'b0, addr: 8'h00, data: 16'h0000, kr: 1'b0, kc: 8'h21,
                       exp_we: 1'b1, exp_addr: 8'hE0 + 8'(i - 12),
                       exp_data: {8'h00, t2_codes[i - 12]}, exp_kw: 1'b1};
        end
        tbl[15] = '{we: 1'b0, addr: 8'h00, data: 16'h0000, kr: 1'b0, kc: 8'h21,
                    exp_we: 1'b0, exp_addr: 8'h00, exp_data: 16'h0000, exp_kw: 1'b0};
        for (int i = 0; i < 16; i++) begin
            iCpuWriteEnable  = tbl[i].we;
            iCpuWriteAddress = tbl[i].addr;
            iCpuDataIn       = tbl[i].data;
            iKeyCodeReady    = tbl[i].kr;
            iKeyCode         = tbl[i].kc;
            #1;
            check($sformatf("t2_vec%0d", i),
                  {oWriteEnable, oWriteAddress, oDataIn, oKeyWritten},
                  {6'd0, tbl[i].exp_we, tbl[i].exp_addr, tbl[i].exp_data, tbl[i].exp_kw});
            step();
        end
        check("t2_head_pending", {oRingHead, oPending}, {4'd3, 5'd3});

        // ---- 17 keys, each consumed: head wraps ----
        do_reset();
        for (int k = 0; k < 17; k++) begin
            send_key(8'h40 + 8'(k));
            iConsume = 1'b1;
            step();
            iConsume = 1'b0;
        end
        check("t3_log_size", kw_log.size(), 17);
        for (int k = 0; k < 17; k++) begin
            check_log($sformatf("t3_key%0d", k), k, {8'hE0 + 8'(k % 16), 8'h00, 8'h40 + 8'(k)});
        end
        check("t3_head_pending", {oRingHead, oPending}, {4'd1, 5'd0});

        // ---- ring full, FIFO fills, overflow ----
        do_reset();
        for (int k = 0; k < 16; k++) send_key(8'h50 + 8'(k));
        check("t4_ring_full", {oPending, oRingHead, oOverflow}, {5'd16, 4'd0, 1'b0});
        for (int k = 0; k < 4; k++) send_key(8'h60 + 8'(k));
        check("t4_fifo_full_no_ovf", {oOverflow, 5'd0} | 32'(kw_log.size()), 32'd16);
        send_key(8'h64);
        check("t4_overflow_set", {oOverflow, oPending}, {1'b1, 5'd16});
        iConsume = 1'b1;
        step();
        iConsume = 1'b0;
        check("t4_pending_after_consume", oPending, 5'd15);
        step();
        step();
        check("t4_log_size", kw_log.size(), 17);
        check_log("t4_oldest_held", 16, {8'hE0, 16'h0060});
        check("t4_refilled", {oPending, oRingHead, oOverflow}, {5'd16, 4'd1, 1'b1});
        iClearOverflow = 1'b1;
        step();
        iClearOverflow = 1'b0;
        check("t4_overflow_cleared", oOverflow, 1'b0);
        send_key(8'h65);
        check("t4_fifo_refull_no_ovf", oOverflow, 1'b0);
        iKeyCode = 8'h66;
        iKeyCodeReady = 1'b1;
        step();
        step();
        iClearOverflow = 1'b1;
        step();
        iClearOverflow = 1'b0;
        check("t4_drop_beats_clear", oOverflow, 1'b1);
        iKeyCodeReady = 1'b0;
        step();
        step();

        // ---- ready held high: one push only ----
        do_reset();
        iKeyCode = 8'h2A;
        iKeyCodeReady = 1'b1;
        for (int c = 0; c < 30; c++) step();
        iKeyCodeReady = 1'b0;
        step();
        step();
        step();
        check("t5_one_write", kw_log.size(), 1);
        check_log("t5_write_data", 0, {8'hE0, 16'h002A});
        check("t5_head_pending", {oRingHead, oPending}, {4'd1, 5'd1});

        // ---- async reset with two codes queued ----
        iCpuWriteEnable  = 1'b1;
        iCpuWriteAddress = 8'h05;
        iCpuDataIn       = 16'h1234;
        send_key(8'h11);
        send_key(8'h22);
        check("t6_cpu_passthru", {oWriteEnable, oWriteAddress, oDataIn, oKeyWritten},
              {6'd0, 1'b1, 8'h05, 16'h1234, 1'b0});
        check("t6_no_kb_write_while_cpu", kw_log.size(), 1);
        iCpuWriteEnable = 1'b0;
        #1;
        check("t6_kb_write_pending", {oWriteEnable, oWriteAddress, oDataIn, oKeyWritten},
              {6'd0, 1'b1, 8'hE1, 16'h0011, 1'b1});
        #2;
        Reset = 1'b1;
        #1;
        check("t6_we_drops_on_reset", {oWriteEnable, oKeyWritten}, 32'h0);
        step();
        step();
        Reset = 1'b0;
        for (int c = 0; c < 5; c++) begin
            step();
            check("t6_no_stale_write", oWriteEnable, 1'b0);
        end
        check("t6_log_unchanged", kw_log.size(), 1);
        check("t6_state_cleared", {oPending, oRingHead, oOverflow}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
